// File: rtl/chan_rd_if.sv
// chan_rd_if: strobe inputs and per-channel read address/strobe/status outputs of chan_rd_sequencer.
interface chan_rd_if #(
  parameter int N_CH  = 5,
  parameter int ADR_W = 5
);
  logic [N_CH-1:0]       strob;
  logic [N_CH-1:0]       rd;
  logic [N_CH*ADR_W-1:0] rd_adr;
  logic [N_CH-1:0]       adr_valid;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       abort;
  logic                  busy;
  modport master (input strob, output rd, rd_adr, adr_valid, done, abort, busy);
  modport slave  (output strob, input rd, rd_adr, adr_valid, done, abort, busy);
endinterface

// File: rtl/chan_rd_sequencer.sv
// chan_rd_sequencer: N-channel slotted read-address/RD-pulse sequencer with optional channel chaining.
module chan_rd_sequencer #(
  parameter int N_CH     = 5,
  parameter int WORDS    = 18,
  parameter int ADR_W    = 5,
  parameter int SLOT_LEN = 64,
  parameter int RD_START = 40,
  parameter int RD_LEN   = 4,
  parameter bit CHAIN_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  chan_rd_if.master bus
);
  localparam int SW = $clog2(SLOT_LEN + 1);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, WAIT = 2'd3;
  localparam logic [SW-1:0] SL_LAST = SW'(SLOT_LEN - 1);
  localparam logic [SW-1:0] RD_LO = SW'(RD_START);
  localparam logic [SW-1:0] RD_HI = SW'(RD_START + RD_LEN - 1);
  localparam logic [ADR_W-1:0] W_LAST = ADR_W'(WORDS - 1);
  if (RD_START + RD_LEN > SLOT_LEN || WORDS > 2 ** ADR_W || RD_LEN < 1 || N_CH < 1) begin : g_bad
    $error("chan_rd_sequencer: illegal parameter set");
  end
  logic [N_CH-1:0] vn;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [1:0]       sy, st, st_n;
    logic [SW-1:0]    slot, slot_n;
    logic [ADR_W-1:0] word, word_n, adr_r;
    logic             go, stay, wrap, last_n, rd_r, v_r, d_r, a_r;
    if (k == 0 || !CHAIN_EN) begin : g_free
      assign go = 1'b1;
    end else begin : g_chain
      assign go = bus.done[k-1];
    end
    // outputs are registered from the next-state decode so they line up with the state they describe
    always_comb begin
      wrap   = slot == SL_LAST;
      st_n   = st == IDLE ? (sy[1] ? ARM : IDLE)
             : st == ARM  ? (!sy[1] ? IDLE : go ? RUN : ARM)
             : st == RUN  ? (wrap && word == W_LAST ? WAIT : sy[1] ? RUN : IDLE)
             :              (sy[1] ? WAIT : IDLE);
      stay   = st == RUN && st_n == RUN;
      slot_n = stay ? (wrap ? '0 : slot + SW'(1)) : '0;
      word_n = stay ? word + ADR_W'(wrap) : '0;
      last_n = st_n == RUN && slot_n == SL_LAST && word_n == W_LAST;
    end
    always_ff @(posedge clk)
      if (rst) begin
        sy    <= '0;
        st    <= IDLE;
        slot  <= '0;
        word  <= '0;
        adr_r <= '0;
        rd_r  <= 1'b0;
        v_r   <= 1'b0;
        d_r   <= 1'b0;
        a_r   <= 1'b0;
      end else begin
        sy    <= {sy[0], bus.strob[k]};
        st    <= st_n;
        slot  <= slot_n;
        word  <= word_n;
        adr_r <= word_n;
        rd_r  <= st_n == RUN && slot_n >= RD_LO && slot_n <= RD_HI;
        v_r   <= st_n == RUN;
        d_r   <= last_n;
        a_r   <= (st_n == ARM || st_n == RUN) && !sy[0] && !last_n;
      end
    assign bus.rd[k]                   = rd_r;
    assign bus.adr_valid[k]            = v_r;
    assign bus.done[k]                 = d_r;
    assign bus.abort[k]                = a_r;
    assign bus.rd_adr[k*ADR_W +: ADR_W] = adr_r;
    assign vn[k]                       = st_n == RUN;
  end
  always_ff @(posedge clk)
    bus.busy <= rst ? 1'b0 : |vn;
endmodule

// File: tb/tb_chan_rd_sequencer.sv
// tb_chan_rd_sequencer: directed bench for a chained default instance and a small unchained instance.
module tb_chan_rd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0, fails = 0;
  int bad_rd = 0, bad_v = 0, bad_adr = 0, bad_done = 0, bad_ab = 0, bad_busy = 0;
  int rises0 = 0, rd0_hi = 0, v0_hi = 0, d0 = 0, busy_hi = 0, first4 = -1, cnt = 0, cnt2 = 0;
  int b_rd = 0, b_done = 0, b_ov = 0, b_busy = 0, nv = 0;
  int t, n, r;
  bit in, e_rd, prev_rd0 = 1'b0;

  chan_rd_if #(.N_CH(5), .ADR_W(5)) a_if ();
  chan_rd_if #(.N_CH(3), .ADR_W(2)) b_if ();

  chan_rd_sequencer dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
  chan_rd_sequencer #(.N_CH(3), .WORDS(4), .ADR_W(2), .SLOT_LEN(8), .RD_START(2), .RD_LEN(1),
                      .CHAIN_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    a_if.strob = '1;
    b_if.strob = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd", 64'(a_if.rd), 0);
    chk("rst_adr", 64'(a_if.rd_adr), 0);
    chk("rst_valid", 64'(a_if.adr_valid), 0);
    chk("rst_done", 64'(a_if.done), 0);
    chk("rst_abort", 64'(a_if.abort), 0);
    chk("rst_busy", 64'(a_if.busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_edge3", 64'(a_if.adr_valid[0]), 0);
    @(negedge clk);
    chk("lat_edge4", 64'(a_if.adr_valid[0]), 1);
    // chained run of all five channels, compared every cycle against a slot/word model
    for (int c = 0; c < 5780; c++) begin
      for (int k = 0; k < 5; k++) begin
        t = c - 1152 * k;
        in = t >= 0 && t < 1152;
        e_rd = in && (t % 64) >= 40 && (t % 64) < 44;
        if (a_if.rd[k] !== e_rd) bad_rd++;
        if (a_if.adr_valid[k] !== in) bad_v++;
        if (a_if.rd_adr[k*5 +: 5] !== 5'(in ? t / 64 : 0)) bad_adr++;
        if (a_if.done[k] !== (in && t == 1151)) bad_done++;
        if (a_if.abort[k] !== 1'b0) bad_ab++;
      end
      if (a_if.busy !== (c < 5760)) bad_busy++;
      if (a_if.rd[0] && !prev_rd0) rises0++;
      prev_rd0 = a_if.rd[0];
      rd0_hi += int'(a_if.rd[0]);
      v0_hi += int'(a_if.adr_valid[0]);
      d0 += int'(a_if.done[0]);
      busy_hi += int'(a_if.busy);
      if (first4 < 0 && a_if.adr_valid[4]) first4 = c;
      @(negedge clk);
    end
    chk("chain_rd", bad_rd, 0);
    chk("chain_valid", bad_v, 0);
    chk("chain_adr", bad_adr, 0);
    chk("chain_done", bad_done, 0);
    chk("chain_abort", bad_ab, 0);
    chk("chain_busy", bad_busy, 0);
    chk("ch0_rd_pulses", rises0, 18);
    chk("ch0_rd_high", rd0_hi, 72);
    chk("ch0_valid_len", v0_hi, 1152);
    chk("ch0_done_cnt", d0, 1);
    chk("busy_len", busy_hi, 5760);
    chk("ch4_start", first4, 4608);
    // strobes dropping from WAIT must not abort
    a_if.strob = '0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(a_if.abort != 0);
    end
    chk("wait_drop_abort", cnt, 0);
    a_if.strob = 5'b00011;
    repeat (4) @(negedge clk);
    chk("rerun_valid", 64'(a_if.adr_valid[0]), 1);
    repeat (490) @(negedge clk);
    chk("mid_rd", 64'(a_if.rd[0]), 1);
    chk("mid_adr", 64'(a_if.rd_adr[4:0]), 7);
    a_if.strob[0] = 1'b0;
    @(negedge clk);
    chk("ab_e1_abort", 64'(a_if.abort[0]), 0);
    chk("ab_e1_valid", 64'(a_if.adr_valid[0]), 1);
    @(negedge clk);
    chk("ab_e2_abort", 64'(a_if.abort[0]), 1);
    @(negedge clk);
    chk("ab_e3_abort", 64'(a_if.abort[0]), 0);
    chk("ab_e3_rd", 64'(a_if.rd[0]), 0);
    chk("ab_e3_valid", 64'(a_if.adr_valid[0]), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(a_if.adr_valid[1] | a_if.rd[1] | a_if.abort[1]);
    end
    chk("ch1_held_arm", cnt, 0);
    a_if.strob[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("ch1_arm_abort", 64'(a_if.abort[1]), 1);
    @(negedge clk);
    chk("ch1_abort_pulse", 64'(a_if.abort[1]), 0);
    // restart from address 0, then late-armed channel 1 must wait for the next done[0]
    a_if.strob[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("restart_valid", 64'(a_if.adr_valid[0]), 1);
    chk("restart_adr", 64'(a_if.rd_adr[4:0]), 0);
    n = 0;
    while (!a_if.done[0] && n < 1300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_len", n, 1151);
    a_if.strob[1] = 1'b1;
    cnt = 0;
    cnt2 = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += int'(a_if.adr_valid[0]);
      cnt2 += int'(a_if.adr_valid[1]);
    end
    chk("no_restart", cnt, 0);
    chk("missed_done_wait", cnt2, 0);
    a_if.strob[0] = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(a_if.abort != 0);
    end
    chk("toggle_abort", cnt, 0);
    a_if.strob[0] = 1'b1;
    n = 0;
    while (!a_if.done[0] && n < 1300) begin
      @(negedge clk);
      n++;
    end
    chk("frame2_len", n, 1155);
    chk("ch1_before_done", 64'(a_if.adr_valid[1]), 0);
    @(negedge clk);
    chk("ch1_chain_start", 64'(a_if.adr_valid[1]), 1);
    chk("ch1_chain_adr", 64'(a_if.rd_adr[9:5]), 0);
    chk("ch0_after_done", 64'(a_if.adr_valid[0]), 0);
    // unchained small instance: strobes at relative clk 0, 5, 11
    bad_rd = 0;
    bad_v = 0;
    bad_adr = 0;
    bad_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) b_if.strob[0] = 1'b1;
      if (c == 5) b_if.strob[1] = 1'b1;
      if (c == 11) b_if.strob[2] = 1'b1;
      nv = 0;
      for (int k = 0; k < 3; k++) begin
        r = k == 0 ? 4 : k == 1 ? 9 : 15;
        t = c - r;
        in = t >= 0 && t < 32;
        e_rd = in && (t % 8) == 2;
        nv += int'(in);
        if (b_if.rd[k] !== e_rd) bad_rd++;
        if (b_if.adr_valid[k] !== in) bad_v++;
        if (b_if.rd_adr[k*2 +: 2] !== 2'(in ? t / 8 : 0)) bad_adr++;
        if (b_if.done[k] !== (in && t == 31)) bad_done++;
        b_rd += int'(b_if.rd[k]);
        b_done += int'(b_if.done[k]);
      end
      b_ov += int'(nv >= 2);
      b_busy += int'(b_if.busy);
      @(negedge clk);
    end
    chk("free_rd", bad_rd, 0);
    chk("free_valid", bad_v, 0);
    chk("free_adr", bad_adr, 0);
    chk("free_done", bad_done, 0);
    chk("free_rd_cnt", b_rd, 12);
    chk("free_done_cnt", b_done, 3);
    chk("free_overlap", b_ov, 32);
    chk("free_busy", b_busy, 43);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/chan_rd_sequencer.md
Name: chan_rd_sequencer

Overview:
- Parametrised N-channel read-address/read-strobe sequencer for the UART transmit buffers.
- Each channel is armed by its frame strobe and walks WORDS buffer addresses. Each address occupies a fixed-length slot with a programmable RD pulse inside it.
- Optional chaining: channel k starts only after channel k-1 finishes its frame.
- Adds frame abort on strobe loss, per-channel done/abort flags, adr_valid qualification (no tri-state) and a global busy flag.

Parameters:
- N_CH, 5, number of channels (1..8)
- WORDS, 18, addresses per frame (2..2^ADR_W)
- ADR_W, 5, address width
- SLOT_LEN, 64, clocks per address slot (power of two not required, >= RD_START+RD_LEN)
- RD_START, 40, slot cycle index at which RD rises
- RD_LEN, 4, RD high duration in clocks (>= 1)
- CHAIN_EN, 1, 1 = channel k>0 waits for done[k-1]; 0 = every channel starts on its own strobe

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- strob  in  N_CH  per-channel frame strobes, asynchronous, level-active
- rd  out  N_CH  per-channel read pulses
- rd_adr  out  N_CH*ADR_W  per-channel read address; channel k occupies bits [k*ADR_W +: ADR_W]
- adr_valid  out  N_CH  high while channel k is in RUN
- done  out  N_CH  1-clock pulse when channel k completes all WORDS slots
- abort  out  N_CH  1-clock pulse when channel k loses its strobe during ARM or RUN
- busy  out  1  OR of all channels in RUN

Behaviour:
- Strobe sync: 2-flop synchronizer per channel (s_k). Synchronizer flops are also cleared by rst.
- Reset (rst=1 at a clk edge): all channels go to IDLE. rd, rd_adr, adr_valid, done, abort and busy are 0. Slot and word counters are 0. Reset mid-frame aborts silently; no abort pulse is generated.
- Per-channel FSM has states IDLE, ARM, RUN, WAIT.
  - IDLE: if s_k=1, go to ARM.
  - ARM: if s_k=0, go to IDLE and pulse abort[k]. Else go to RUN when the start condition holds.
    - Start condition for k=0, or when CHAIN_EN=0: immediately, so ARM lasts exactly 1 clock.
    - Start condition for k>0 with CHAIN_EN=1: done[k-1]=1 in that cycle. done[k-1] is not remembered; a done pulse issued before channel k reaches ARM is missed, and k waits for the next one.
  - RUN: slot_cnt counts 0..SLOT_LEN-1, and word counts 0..WORDS-1.
    - When slot_cnt wraps to 0, word increments.
    - At slot_cnt=SLOT_LEN-1 with word=WORDS-1: pulse done[k] and go to WAIT.
    - Frame length is exactly WORDS*SLOT_LEN clocks, with no gap cycles between slots.
  - RUN abort: if s_k=0, go to IDLE and pulse abort[k]. rd, adr_valid and the counters clear on the next clock.
    - If abort and completion occur in the same cycle, completion wins: done pulses and abort does not.
  - WAIT: if s_k=0, go to IDLE. A channel never re-runs without its strobe first going low.
- Outputs are registered.
  - rd[k]=1 exactly when in RUN and RD_START <= slot_cnt <= RD_START+RD_LEN-1.
  - rd_adr[k] = word while in RUN, otherwise 0.
  - adr_valid[k] = (state==RUN).
- Address is stable across the whole slot, including RD_START-1 through RD_LEN after it.
- Latency: strob rising → first RUN cycle is 2 sync clocks + 1 IDLE→ARM clock + 1 ARM→RUN clock for an unchained channel. rd then rises RD_START clocks after RUN entry.
- Chained start: channel k enters RUN on the clock after done[k-1]. Its slot_cnt=0 cycle immediately follows channel k-1's last RUN cycle.
- Channels are fully independent apart from the chaining input. A chain break (channel k-1 aborted) leaves channel k in ARM until its strobe drops or a later done[k-1] arrives.
- Elaboration checks (assertion / $error): RD_START+RD_LEN <= SLOT_LEN; WORDS <= 2^ADR_W; RD_LEN >= 1; N_CH >= 1.

Test Plan:
- Reset: hold rst for 3 clk with strob=all-ones → all outputs 0. After release, channel 0 enters RUN 4 clk after strob was first sampled high.
- Single channel (defaults, strob[0] held high):
  - rd[0] pulses 18 times, each 4 clk, rising at RUN+40+64n.
  - rd_adr0 steps 0..17; adr_valid high for 1152 clk.
  - done[0] pulses once in the last RUN cycle.
  - No restart until strob[0] toggles low then high.
- Chain (CHAIN_EN=1): all strobes high together → channels 0..4 run back-to-back.
  - Channel k's first RUN cycle is 1152*k clk after channel 0's.
  - busy is high continuously for 5760 clk.
- Abort: drop strob[0] at slot 7, cycle 42 (mid-RD).
  - abort[0] pulses; rd[0] and adr_valid[0] are 0 within 3 clk (sync + 1).
  - Channel 1 stays in ARM, rd[1]=0.
  - Re-raising strob[0] restarts at address 0.
- Unchained (CHAIN_EN=0, N_CH=3, WORDS=4, SLOT_LEN=8, RD_START=2, RD_LEN=1): strobes raised at clk 0, 5 and 11.
  - Each channel runs 32 clk independently, with overlapping rd pulses at slot cycle 2 only.
- Boundary: strob[1] held high only after done[0] has already pulsed → channel 1 waits in ARM. The next channel-0 frame's done[0] starts it the following clk.
